// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: single-clock first-word-fall-through pixel buffer feeding
// vga_logic. The head pixel is held in a register, so pixel_out and every
// status flag are driven by flops only. rd_en and wr_en have no combinational
// path to any output.
module vga_pixel_fifo #(
    parameter  int WIDTH     = 24,
    parameter  int DEPTH     = 64,
    parameter  int AF_THRESH = 48,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] pixel_out,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             almost_full,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] pixel_out_r;
    logic             empty_r;
    logic             full_r;
    logic             almost_full_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             pop_acc_s;
    logic             push_acc_s;
    logic             mem_we_s;
    logic [LW-1:0]    level_next_s;
    logic [WIDTH-1:0] head_next_s;
    logic             overflow_set_s;
    logic             underflow_set_s;

    // Handshake decode, next level and next head pixel.
    always_comb begin
        pop_acc_s       = rd_en & ~empty_r;
        push_acc_s      = wr_en & (~full_r | pop_acc_s);
        mem_we_s        = push_acc_s & ~flush;
        overflow_set_s  = wr_en & full_r & ~pop_acc_s;
        underflow_set_s = rd_en & empty_r;
        level_next_s    = level_r + LW'(push_acc_s) - LW'(pop_acc_s);
        head_next_s     = pixel_out_r;
        if (pop_acc_s) begin
            if (level_r == LW'(1)) begin
                // Last entry leaves; a same-cycle push becomes the new head.
                if (push_acc_s) begin
                    head_next_s = wr_data;
                end else begin
                    head_next_s = pixel_out_r;
                end
            end else begin
                head_next_s = mem_r[rd_ptr_r + AW'(1)];
            end
        end else if (push_acc_s && empty_r) begin
            // Write into empty falls straight through to the head register.
            head_next_s = wr_data;
        end else begin
            head_next_s = pixel_out_r;
        end
    end

    // Storage array write port; contents need no reset since level gates them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, level, head register and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            level_r       <= {LW{1'b0}};
            pixel_out_r   <= {WIDTH{1'b0}};
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            level_r       <= {LW{1'b0}};
            pixel_out_r   <= {WIDTH{1'b0}};
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r       <= level_next_s;
            pixel_out_r   <= head_next_s;
            empty_r       <= (level_next_s == {LW{1'b0}});
            full_r        <= (level_next_s == LW'(DEPTH));
            almost_full_r <= (level_next_s >= LW'(AF_THRESH));
            overflow_r    <= overflow_r | overflow_set_s;
            underflow_r   <= underflow_r | underflow_set_s;
        end
    end

    assign pixel_out   = pixel_out_r;
    assign fifo_empty  = empty_r;
    assign fifo_full   = full_r;
    assign almost_full = almost_full_r;
    assign level       = level_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_vga_pixel_fifo;

    localparam int WIDTH     = 24;
    localparam int DEPTH     = 64;
    localparam int AF_THRESH = 48;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] pixel_out;
    logic             fifo_empty;
    logic             fifo_full;
    logic             almost_full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_px;
    logic             m_ovf;
    logic             m_unf;

    vga_pixel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .pixel_out(pixel_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_px  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic fl);
        bit pop, push;
        if (fl) begin
            model_reset();
        end else begin
            pop  = rd && (q.size() > 0);
            push = wr && ((q.size() < DEPTH) || pop);
            if (wr && (q.size() == DEPTH) && !pop) m_ovf = 1'b1;
            if (rd && (q.size() == 0)) m_unf = 1'b1;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(wd);
            if (q.size() > 0) m_px = q[0];
        end
    endtask

    task automatic check_all();
        check_val("level",       32'(level),       32'(q.size()));
        check_val("fifo_empty",  32'(fifo_empty),  32'(q.size() == 0));
        check_val("fifo_full",   32'(fifo_full),   32'(q.size() == DEPTH));
        check_val("almost_full", 32'(almost_full), 32'(q.size() >= AF_THRESH));
        check_val("overflow",    32'(overflow),    32'(m_ovf));
        check_val("underflow",   32'(underflow),   32'(m_unf));
        check_val("pixel_out",   32'(pixel_out),   32'(m_px));
    endtask

    task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic fl);
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        flush   = fl;
        @(posedge clk);
        model_step(wr, wd, rd, fl);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check_all();
    endtask

    initial begin
        int next_val;
        int exp_pop;
        bit rd;
        bit wr;
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        #12;
        check_all();                         // reset state
        rst = 1'b1;
        @(posedge clk); #1;

        // Async reset mid-cycle with data stored
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_val("rst_async_empty", 32'(fifo_empty), 32'd1);
        check_val("rst_async_level", 32'(level), 32'd0);
        check_all();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        check_val("first_push_px", 32'(pixel_out), 32'h00FFFFFF);

        // Order and wrap: 100 pixels, level kept at or below 40
        step(1'b0, '0, 1'b0, 1'b1);
        next_val = 1;
        exp_pop  = 1;
        while (exp_pop <= 100) begin
            wr = (next_val <= 100) && (q.size() < 40) && ($urandom_range(0, 3) != 0);
            rd = (q.size() > 0) && ($urandom_range(0, 2) == 0 || next_val > 100);
            if (rd) begin
                check_val("order_px", 32'(pixel_out), 32'(exp_pop));
                exp_pop++;
            end
            step(wr, WIDTH'(next_val), rd, 1'b0);
            check_val("order_no_af", 32'(almost_full), 32'd0);
            if (wr) next_val++;
        end

        // Fill to full, then overflow attempt
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, WIDTH'(32'h200 + i), 1'b0, 1'b0);
            if (i == AF_THRESH - 1) check_val("af_before", 32'(almost_full), 32'd0);
            if (i == AF_THRESH)     check_val("af_at", 32'(almost_full), 32'd1);
        end
        check_val("full_at_64", 32'(fifo_full), 32'd1);
        step(1'b1, 24'h123456, 1'b0, 1'b0);
        check_val("ovf_set", 32'(overflow), 32'd1);
        check_val("ovf_head", 32'(pixel_out), 32'h201);

        // Push+pop while full; pushed pixel must come out last
        step(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
        check_val("full_pp_level", 32'(level), 32'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("full_pp_last", 32'(pixel_out), 32'h5A5A5A);
        step(1'b0, '0, 1'b1, 1'b0);

        // Underflow and simultaneous write into empty
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("unf_set", 32'(underflow), 32'd1);
        step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        check_val("empty_wr_rd_lvl", 32'(level), 32'd1);
        check_val("empty_wr_rd_px", 32'(pixel_out), 32'hABCDEF);
        // Level 1 with push and pop
        step(1'b1, 24'h13579B, 1'b1, 1'b0);
        check_val("lvl1_pp_px", 32'(pixel_out), 32'h13579B);

        // Flush with level 20 and overflow set, write discarded
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 20; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("pre_flush_lvl", 32'(level), 32'd20);
        step(1'b1, 24'h777777, 1'b0, 1'b1);
        check_val("flush_lvl", 32'(level), 32'd0);
        check_val("flush_ovf", 32'(overflow), 32'd0);
        check_val("flush_empty", 32'(fifo_empty), 32'd1);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 250) % 2 == 0 ? 3 : 1;
            step(($urandom_range(0, 3) < bias), WIDTH'($urandom), ($urandom_range(0, 3) >= bias),
                 ($urandom_range(0, 199) == 0));
        end

        // vga_logic style consumer: one 800-cycle line, 640 active
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        for (int c = 0; c < 800; c++) begin
            rd = (c < 640);
            if (rd) begin
                check_val("vga_red",   32'(pixel_out[23:16]), 32'hFF);
                check_val("vga_green", 32'(pixel_out[15:8]),  32'hFF);
                check_val("vga_blue",  32'(pixel_out[7:0]),   32'hFF);
            end
            step((q.size() < 32), 24'hFFFFFF, rd, 1'b0);
        end
        check_val("vga_no_unf", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
